// File: rtl/min2_stream_tracker.sv
module min2_stream_tracker #(
  parameter int QUAN_SIZE = 3,
  parameter int DC        = 6,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QUAN_SIZE-1:0] in_mag,
  input  logic                 in_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUAN_SIZE-1:0] out_min1,
  output logic [QUAN_SIZE-1:0] out_min2,
  output logic [IDX_WIDTH-1:0] out_min_index,
  output logic                 out_sign_xor,
  output logic [IDX_WIDTH-1:0] beat_cnt
);

  localparam logic [IDX_WIDTH-1:0] LAST_BEAT = IDX_WIDTH'(DC - 1);

  logic [QUAN_SIZE-1:0] acc_min1, acc_min2;
  logic [IDX_WIDTH-1:0] acc_idx;
  logic                 acc_sign;

  logic [QUAN_SIZE-1:0] nxt_min1, nxt_min2;
  logic [IDX_WIDTH-1:0] nxt_idx;
  logic                 nxt_sign;

  logic last_beat, accept, complete;

  assign last_beat = (beat_cnt == LAST_BEAT);
  // Only the completing beat stalls while an earlier result is still held.
  assign in_ready  = !(last_beat && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && last_beat;

  always_comb begin
    nxt_min1 = acc_min1;
    nxt_min2 = acc_min2;
    nxt_idx  = acc_idx;
    nxt_sign = acc_sign ^ in_sign;
    if (beat_cnt == '0) begin
      nxt_min1 = in_mag;
      nxt_min2 = '1;
      nxt_idx  = '0;
      nxt_sign = in_sign;
    end else if (in_mag < acc_min1) begin
      nxt_min2 = acc_min1;
      nxt_min1 = in_mag;
      nxt_idx  = beat_cnt;
    end else if (in_mag < acc_min2) begin
      nxt_min2 = in_mag;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      beat_cnt      <= '0;
      acc_min1      <= '0;
      acc_min2      <= '0;
      acc_idx       <= '0;
      acc_sign      <= 1'b0;
      out_valid     <= 1'b0;
      out_min1      <= '0;
      out_min2      <= '0;
      out_min_index <= '0;
      out_sign_xor  <= 1'b0;
    end else begin
      if (accept) begin
        acc_min1 <= nxt_min1;
        acc_min2 <= nxt_min2;
        acc_idx  <= nxt_idx;
        acc_sign <= nxt_sign;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (complete) begin
        out_valid     <= 1'b1;
        out_min1      <= nxt_min1;
        out_min2      <= nxt_min2;
        out_min_index <= nxt_idx;
        out_sign_xor  <= nxt_sign;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_min2_stream_tracker.sv
module tb_min2_stream_tracker;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] idx;
    logic       sx;
  } res_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_mag;
  logic       in_sign;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_min1;
  logic [2:0] out_min2;
  logic [2:0] out_min_index;
  logic       out_sign_xor;
  logic [2:0] beat_cnt;

  res_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  min2_stream_tracker #(
    .QUAN_SIZE(3),
    .DC(6),
    .IDX_WIDTH(3)
  ) dut (
    .sys_clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mag(in_mag),
    .in_sign(in_sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_min1(out_min1),
    .out_min2(out_min2),
    .out_min_index(out_min_index),
    .out_sign_xor(out_sign_xor),
    .beat_cnt(beat_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input int m1, input int m2, input int idx, input int sx);
    res_t r;
    r.m1  = 3'(m1);
    r.m2  = 3'(m2);
    r.idx = 3'(idx);
    r.sx  = 1'(sx);
    q.push_back(r);
    n_push++;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&ready hold here.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_result: got min1=%0d with no expected result queued", out_min1);
      end else begin
        res_t e;
        e = q.pop_front();
        n_pop++;
        chk("min1", int'(out_min1), int'(e.m1));
        chk("min2", int'(out_min2), int'(e.m2));
        chk("min_index", int'(out_min_index), int'(e.idx));
        chk("sign_xor", int'(out_sign_xor), int'(e.sx));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Called and returns at posedge+1.
  task automatic send_beat(input int m, input int s, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_mag   = 3'(m);
    in_sign  = 1'(s);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mag   = 3'($urandom);
    in_sign  = 1'($urandom);
  endtask

  task automatic send_frame(input int ma[6], input int sa[6], input int gapmax);
    for (int i = 0; i < 6; i++) send_beat(ma[i], sa[i], $urandom_range(0, gapmax));
  endtask

  function automatic res_t model(input int ma[6], input int sa[6]);
    res_t r;
    int   m1, m2, idx, sx;
    m1 = 8; idx = 0; sx = 0;
    for (int i = 0; i < 6; i++) begin
      sx ^= sa[i];
      if (ma[i] < m1) begin m1 = ma[i]; idx = i; end
    end
    m2 = 8;
    for (int i = 0; i < 6; i++) if (i != idx && ma[i] < m2) m2 = ma[i];
    r.m1 = 3'(m1); r.m2 = 3'(m2); r.idx = 3'(idx); r.sx = 1'(sx);
    return r;
  endfunction

  initial begin
    int ma[6];
    int sa[6];
    int n;
    res_t r;

    rstn = 1'b0; in_valid = 1'b0; in_mag = '0; in_sign = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_beat_cnt", int'(beat_cnt), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_min1", int'(out_min1), 0);
    chk("rst_min2", int'(out_min2), 0);
    chk("rst_index", int'(out_min_index), 0);
    chk("rst_sign", int'(out_sign_xor), 0);
    rstn = 1'b1;

    // Frame 1 with latency check
    ma = '{5, 3, 6, 2, 7, 4}; sa = '{1, 0, 1, 1, 0, 0};
    push_exp(2, 3, 3, 1);
    for (int i = 0; i < 5; i++) send_beat(ma[i], sa[i], 0);
    chk("f1_valid_before_last", int'(out_valid), 0);
    chk("f1_beat_cnt_at_last", int'(beat_cnt), 5);
    send_beat(ma[5], sa[5], 0);
    chk("f1_valid_latency", int'(out_valid), 1);
    chk("f1_beat_cnt_wrap", int'(beat_cnt), 0);
    @(posedge clk); #1;
    chk("f1_valid_drop", int'(out_valid), 0);

    ma = '{4, 1, 1, 7, 1, 5}; sa = '{0, 1, 1, 1, 0, 0};
    push_exp(1, 1, 1, 1);
    send_frame(ma, sa, 0);

    ma = '{7, 7, 7, 7, 7, 7}; sa = '{1, 1, 1, 1, 1, 1};
    push_exp(7, 7, 0, 0);
    send_frame(ma, sa, 1);

    ma = '{7, 6, 5, 4, 3, 2}; sa = '{1, 0, 0, 0, 0, 0};
    push_exp(2, 3, 5, 1);
    send_frame(ma, sa, 0);
    @(posedge clk); #1;

    // Backpressure: A waits, B streams, only B's last beat stalls
    out_ready = 1'b0;
    ma = '{3, 5, 1, 4, 2, 6}; sa = '{1, 1, 1, 0, 0, 0};
    push_exp(1, 2, 2, 1);
    send_frame(ma, sa, 0);
    ma = '{0, 7, 7, 7, 7, 0}; sa = '{0, 0, 0, 0, 0, 1};
    push_exp(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) send_beat(ma[i], sa[i], 0);
    in_valid = 1'b1; in_mag = 3'(ma[5]); in_sign = 1'(sa[5]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_a_min1_stable", int'(out_min1), 1);
      chk("bp_a_index_stable", int'(out_min_index), 2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_valid_no_gap", int'(out_valid), 1);
    chk("bp_b_loaded_min2", int'(out_min2), 0);
    @(posedge clk); #1;
    chk("bp_valid_drop", int'(out_valid), 0);

    // Reset mid-frame
    ma = '{1, 1, 1, 1, 1, 1}; sa = '{1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 3; i++) send_beat(ma[i], sa[i], 0);
    chk("mid_beat_cnt", int'(beat_cnt), 3);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_beat_cnt", int'(beat_cnt), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_min1", int'(out_min1), 0);
    chk("mid_rst_min2", int'(out_min2), 0);
    chk("mid_rst_index", int'(out_min_index), 0);
    chk("mid_rst_sign", int'(out_sign_xor), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    ma = '{6, 6, 6, 6, 6, 0}; sa = '{0, 0, 0, 0, 0, 0};
    push_exp(0, 6, 5, 0);
    send_frame(ma, sa, 0);

    // Randomised gaps and backpressure against the reference model
    rand_ready = 1'b1;
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < 6; i++) begin
        ma[i] = $urandom_range(0, 7);
        sa[i] = $urandom_range(0, 1);
      end
      r = model(ma, sa);
      push_exp(int'(r.m1), int'(r.m2), int'(r.idx), int'(r.sx));
      send_frame(ma, sa, 2);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    chk("frames_vs_transfers", n_pop, n_push);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
